// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - loader FSM state type and sizing constants
package uart_loader_pkg;
`include "loader_defines.v"

  localparam int LEN_W                = `LOADER_LEN_W;
  localparam int DEFAULT_CLKS_PER_BIT = `LOADER_CLKS_PER_BIT;

  typedef enum logic [2:0] {
    LEN_LO  = `LOADER_ST_LEN_LO,
    LEN_HI  = `LOADER_ST_LEN_HI,
    PAYLOAD = `LOADER_ST_PAYLOAD,
    CHECK   = `LOADER_ST_CHECK,
    DONE    = `LOADER_ST_DONE,
    ERROR   = `LOADER_ST_ERROR
  } loader_state_t;
endpackage

// File: rtl/loader_defines.v
// rtl/loader_defines.v - shared loader state encodings, length width and default bit timing
`ifndef LOADER_DEFINES_V
`define LOADER_DEFINES_V

`define LOADER_ST_LEN_LO   3'd0
`define LOADER_ST_LEN_HI   3'd1
`define LOADER_ST_PAYLOAD  3'd2
`define LOADER_ST_CHECK    3'd3
`define LOADER_ST_DONE     3'd4
`define LOADER_ST_ERROR    3'd5

`define LOADER_LEN_W        16
`define LOADER_CLKS_PER_BIT 16

`endif

// File: rtl/uart_loader_rx.sv
// rtl/uart_loader_rx.sv - 8N1 receiver: 2-flop synchronizer plus mid-bit sampler
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     state, state_nxt;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift, shift_nxt, byte_nxt;
  logic          valid_nxt, ferr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_valid  <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      shift     <= shift_nxt;
      rx_valid  <= valid_nxt;
      rx_byte   <= byte_nxt;
      frame_err <= ferr_nxt;
    end
  end

  // Edge-triggered start so a line stuck low after a bad stop bit does not retrigger.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    byte_nxt  = rx_byte;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (rx_prev && !rx_sync) state_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_M1) begin
          cnt_nxt = '0;
          bit_nxt = '0;
          state_nxt = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_sync, shift[7:1]};
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
          else                 bit_nxt   = bit_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_nxt   = '0;
          state_nxt = RX_IDLE;
          if (rx_sync) begin
            valid_nxt = 1'b1;
            byte_nxt  = shift;
          end else begin
            ferr_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - UART boot loader top; optional trailing checksum via UART_LOADER_CHECKSUM_EN
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] mem_address,
  output logic [7:0]  mem_write_data,
  output logic        mem_write_enable,
  output logic        cpu_rst,
  output logic        loading,
  output logic        error
);
  logic             rx_valid;
  logic [7:0]       rx_byte;
  logic             frame_err;
  loader_state_t    state, state_nxt;
  logic [LEN_W-1:0] len, index;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]       sum;
`endif

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= LEN_LO;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_rst   = (state != DONE);
    loading   = (state != DONE);
    error     = (state == ERROR);
    case (state)
      LEN_LO: begin
        if (frame_err)     state_nxt = ERROR;
        else if (rx_valid) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        if (frame_err) state_nxt = ERROR;
        else if (rx_valid) begin
          if ({rx_byte, len[7:0]} == '0)
`ifdef UART_LOADER_CHECKSUM_EN
            state_nxt = CHECK;
`else
            state_nxt = DONE;
`endif
          else
            state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (frame_err) state_nxt = ERROR;
`ifdef UART_LOADER_CHECKSUM_EN
        else if (rx_valid && (index + LEN_W'(1)) == len) state_nxt = CHECK;
`else
        // Release one cycle after the final strobe, not alongside it.
        else if (mem_write_enable && index == len) state_nxt = DONE;
`endif
      end
`ifdef UART_LOADER_CHECKSUM_EN
      CHECK: begin
        if (frame_err)     state_nxt = ERROR;
        else if (rx_valid) state_nxt = (rx_byte == sum) ? DONE : ERROR;
      end
`endif
      DONE, ERROR: state_nxt = state;
      default:     state_nxt = ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len              <= '0;
      index            <= '0;
      mem_address      <= BASE_ADDR;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      sum              <= '0;
`endif
    end else begin
      mem_write_enable <= 1'b0;
      if (rx_valid) begin
        case (state)
          LEN_LO: len[7:0] <= rx_byte;
          LEN_HI: begin
            len[LEN_W-1:8] <= rx_byte;
            index          <= '0;
          end
          PAYLOAD: begin
            mem_write_enable <= 1'b1;
            mem_address      <= BASE_ADDR + 32'(index);
            mem_write_data   <= rx_byte;
            index            <= index + LEN_W'(1);
`ifdef UART_LOADER_CHECKSUM_EN
            sum              <= sum + rx_byte;
`endif
          end
          default: ;
        endcase
      end
    end
  end
endmodule
